// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction queue between fetch and dual-issue decode.
// Optional IBUF_PERF_CNT_EN adds full-cycle and dual-issue-cycle performance counters.
`ifndef EXC_CODE_BUS
`define EXC_CODE_BUS 5:0
`endif
`ifndef EXC_NONE
`define EXC_NONE 6'h00
`endif

module inst_buffer #(
  parameter int DEPTH       = 16,
  parameter int PTR_W       = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 push_valid_i,
  input  logic [31:0]          push_pc_i,
  input  logic [31:0]          push_inst_i,
  input  logic [`EXC_CODE_BUS] push_exccode_i,
  input  logic [1:0]           issue_cnt_i,
  output logic                 inst0_valid_o,
  output logic [31:0]          inst0_pc_o,
  output logic [31:0]          inst0_inst_o,
  output logic [`EXC_CODE_BUS] inst0_exccode_o,
  output logic                 inst1_valid_o,
  output logic [31:0]          inst1_pc_o,
  output logic [31:0]          inst1_inst_o,
  output logic [`EXC_CODE_BUS] inst1_exccode_o,
  output logic                 buf_full_o,
`ifdef IBUF_PERF_CNT_EN
  output logic [31:0]          perf_full_cyc_o,
  output logic [31:0]          perf_dual_cyc_o,
`endif
  output logic                 overflow_o
);
  localparam int CW = PTR_W + 1;
  logic [31:0]          r_pc   [DEPTH];
  logic [31:0]          r_inst [DEPTH];
  logic [`EXC_CODE_BUS] r_exc  [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr, r_wr_ptr, w_rd_ptr1;
  logic [CW-1:0]        r_count, w_req, w_pop_n;
  logic                 w_push_acc, r_overflow;
  // pops free space before the push is judged, so a full buffer still accepts while draining
  always_comb begin
    w_req      = issue_cnt_i[1] ? CW'(2) : CW'(issue_cnt_i[0]);
    w_pop_n    = (r_count < w_req) ? r_count : w_req;
    w_push_acc = push_valid_i && ((r_count - w_pop_n) < CW'(DEPTH));
    w_rd_ptr1  = r_rd_ptr + PTR_W'(1);
  end
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + w_pop_n[PTR_W-1:0];
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_acc);
      r_count  <= r_count + CW'(w_push_acc) - w_pop_n;
      if (push_valid_i && !w_push_acc) r_overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn && !flush && w_push_acc) begin
      r_pc[r_wr_ptr]   <= push_pc_i;
      r_inst[r_wr_ptr] <= push_inst_i;
      r_exc[r_wr_ptr]  <= push_exccode_i;
    end
  end
`ifdef IBUF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (resetn) begin
      perf_full_cyc_o <= '0;
      perf_dual_cyc_o <= '0;
    end else begin
      if (buf_full_o) perf_full_cyc_o <= perf_full_cyc_o + 32'd1;
      if (!flush && w_pop_n == CW'(2)) perf_dual_cyc_o <= perf_dual_cyc_o + 32'd1;
    end
  end
`endif
  assign inst0_valid_o   = r_count >= CW'(1);
  assign inst1_valid_o   = r_count >= CW'(2);
  assign inst0_pc_o      = r_pc[r_rd_ptr];
  assign inst0_inst_o    = r_inst[r_rd_ptr];
  assign inst0_exccode_o = r_exc[r_rd_ptr];
  assign inst1_pc_o      = r_pc[w_rd_ptr1];
  assign inst1_inst_o    = r_inst[w_rd_ptr1];
  assign inst1_exccode_o = r_exc[w_rd_ptr1];
  assign buf_full_o      = r_count >= CW'(DEPTH - FULL_MARGIN);
  assign overflow_o      = r_overflow;
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: queue-model scoreboard for inst_buffer with directed and random stimulus.
`ifndef EXC_CODE_BUS
`define EXC_CODE_BUS 5:0
`endif

module tb_inst_buffer;
  localparam int DEPTH = 16;
  localparam int FULL_AT = DEPTH - 2;
  logic clk = 1'b0;
  logic resetn, flush, push_valid_i;
  logic [31:0] push_pc_i, push_inst_i;
  logic [`EXC_CODE_BUS] push_exccode_i;
  logic [1:0] issue_cnt_i;
  logic inst0_valid_o, inst1_valid_o, buf_full_o, overflow_o;
  logic [31:0] inst0_pc_o, inst0_inst_o, inst1_pc_o, inst1_inst_o;
  logic [`EXC_CODE_BUS] inst0_exccode_o, inst1_exccode_o;
`ifdef IBUF_PERF_CNT_EN
  logic [31:0] perf_full_cyc_o, perf_dual_cyc_o;
  logic [31:0] m_full_cyc, m_dual_cyc;
`endif

  inst_buffer dut (
    .clk(clk), .resetn(resetn), .flush(flush), .push_valid_i(push_valid_i),
    .push_pc_i(push_pc_i), .push_inst_i(push_inst_i), .push_exccode_i(push_exccode_i),
    .issue_cnt_i(issue_cnt_i),
    .inst0_valid_o(inst0_valid_o), .inst0_pc_o(inst0_pc_o), .inst0_inst_o(inst0_inst_o),
    .inst0_exccode_o(inst0_exccode_o),
    .inst1_valid_o(inst1_valid_o), .inst1_pc_o(inst1_pc_o), .inst1_inst_o(inst1_inst_o),
    .inst1_exccode_o(inst1_exccode_o),
    .buf_full_o(buf_full_o),
`ifdef IBUF_PERF_CNT_EN
    .perf_full_cyc_o(perf_full_cyc_o), .perf_dual_cyc_o(perf_dual_cyc_o),
`endif
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [`EXC_CODE_BUS] exc;
  } ent_t;

  ent_t exp_q[$];
  int issued[$];
  bit m_ov, mon_en, log_en;
  int tests, fails;
  int req, pn, dn;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: an ordered queue of words with pop-before-push capacity rule
  always @(posedge clk) begin
    if (resetn) begin
      exp_q.delete();
      m_ov = 1'b0;
      mon_en = 1'b1;
`ifdef IBUF_PERF_CNT_EN
      m_full_cyc = 0;
      m_dual_cyc = 0;
`endif
    end else begin
`ifdef IBUF_PERF_CNT_EN
      if (exp_q.size() >= FULL_AT) m_full_cyc++;
`endif
      if (flush) exp_q.delete();
      else begin
        req = (issue_cnt_i >= 2) ? 2 : int'(issue_cnt_i);
        pn = (req < exp_q.size()) ? req : exp_q.size();
`ifdef IBUF_PERF_CNT_EN
        if (pn == 2) m_dual_cyc++;
`endif
        repeat (pn) void'(exp_q.pop_front());
        if (push_valid_i) begin
          if (exp_q.size() < DEPTH) exp_q.push_back('{push_pc_i, push_inst_i, push_exccode_i});
          else m_ov = 1'b1;
        end
      end
    end
  end

  // monitor: compare presented entries and status against the model between edges
  always @(negedge clk) begin
    if (mon_en) begin
      chk("inst0_valid", inst0_valid_o, exp_q.size() >= 1);
      chk("inst1_valid", inst1_valid_o, exp_q.size() >= 2);
      chk("buf_full", buf_full_o, exp_q.size() >= FULL_AT);
      chk("overflow", overflow_o, m_ov);
      if (exp_q.size() >= 1) chk("inst0_entry", {inst0_pc_o, inst0_inst_o, inst0_exccode_o}, exp_q[0]);
      if (exp_q.size() >= 2) chk("inst1_entry", {inst1_pc_o, inst1_inst_o, inst1_exccode_o}, exp_q[1]);
`ifdef IBUF_PERF_CNT_EN
      chk("perf_full", perf_full_cyc_o, m_full_cyc);
      chk("perf_dual", perf_dual_cyc_o, m_dual_cyc);
`endif
    end
    if (log_en) begin
      dn = (issue_cnt_i >= 2) ? 2 : int'(issue_cnt_i);
      if (dn > int'(inst0_valid_o) + int'(inst1_valid_o)) dn = int'(inst0_valid_o) + int'(inst1_valid_o);
      if (dn >= 1) issued.push_back(int'(inst0_pc_o));
      if (dn >= 2) issued.push_back(int'(inst1_pc_o));
    end
  end

  task automatic step(input bit pv, input logic [31:0] pc, input logic [1:0] iss, input bit fl);
    logic [31:0] r;
    r = $urandom;
    push_valid_i = pv;
    push_pc_i = pc;
    push_inst_i = $urandom;
    push_exccode_i = r[$bits(push_exccode_i)-1:0];
    issue_cnt_i = iss;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad, ph;
    resetn = 1'b1; flush = 1'b0; push_valid_i = 1'b0; push_pc_i = '0;
    push_inst_i = '0; push_exccode_i = '0; issue_cnt_i = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    chk("rst_valid0", inst0_valid_o, 1'b0);
    chk("rst_valid1", inst1_valid_o, 1'b0);
    chk("rst_full", buf_full_o, 1'b0);
    chk("rst_overflow", overflow_o, 1'b0);
    step(1, 32'hBFC00000, 0, 0);
    step(1, 32'hBFC00004, 0, 0);
    step(1, 32'hBFC00008, 0, 0);
    chk("t2_pc0", inst0_pc_o, 32'hBFC00000);
    chk("t2_pc1", inst1_pc_o, 32'hBFC00004);
    step(0, 0, 2, 0);
    chk("t2_pc0_next", inst0_pc_o, 32'hBFC00008);
    chk("t2_valid1_next", inst1_valid_o, 1'b0);
    step(0, 0, 2, 0);
    chk("t3_valid0", inst0_valid_o, 1'b0);
    for (int i = 0; i < 14; i++) step(1, 32'h1000 + 4 * i, 0, 0);
    chk("t4_full14", buf_full_o, 1'b1);
    step(1, 32'h1038, 0, 0);
    step(1, 32'h103C, 0, 0);
    chk("t4_ovf16", overflow_o, 1'b0);
    step(1, 32'h1040, 0, 0);
    chk("t4_ovf17", overflow_o, 1'b1);
    step(1, 32'h1044, 1, 0);
    chk("t4_head_after_pop", inst0_pc_o, 32'h1004);
    step(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 32'h2000 + 4 * i, 0, 0);
    step(1, 32'h3000, 2, 1);
    chk("t5_valid0", inst0_valid_o, 1'b0);
    chk("t5_full", buf_full_o, 1'b0);
    resetn = 1'b1;
    step(0, 0, 0, 0);
    resetn = 1'b0;
    issued.delete();
    log_en = 1'b1;
    for (int i = 0; i < 100; i++) step(1, 32'(4 * i), (i % 2) ? 2'd2 : 2'd1, 0);
    repeat (10) step(0, 0, 2, 0);
    log_en = 1'b0;
    chk("t6_count", issued.size(), 100);
    bad = 0;
    foreach (issued[k]) if (issued[k] != 4 * k) bad++;
    chk("t6_order", bad, 0);
    resetn = 1'b1;
    step(0, 0, 0, 0);
    resetn = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      ph = (k / 150) % 3;
      resetn = ($urandom_range(0, 499) == 0);
      if (ph == 0) step($urandom_range(0, 9) != 0, $urandom, ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0, $urandom_range(0, 99) == 0);
      else if (ph == 1) step($urandom_range(0, 3) == 0, $urandom, 2'($urandom), $urandom_range(0, 99) == 0);
      else step($urandom_range(0, 1) == 1, $urandom, 2'($urandom), $urandom_range(0, 49) == 0);
    end
    resetn = 1'b0;
    step(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
